hex_printer: RTL and testbench
==============================

HEX_PRINTER -- requirements
Module: hex_printer

Interface
REQ-001 Parameter HEX_UPPER, default 1: hex digits A-F are uppercase (0x41-0x46) when 1 and lowercase (0x61-0x66) when 0.
REQ-002 Parameter WORD_CRLF, default 1: a word print is followed by CR (0x0D) and LF (0x0A) when 1, with no terminator when 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 d_tx  output  8  character byte to the UART transmitter.
REQ-006 vld_tx  output  1  d_tx is valid.
REQ-007 rdy_tx  input  1  UART transmitter can accept a byte this cycle.
REQ-008 req_tx  input  1  print request from the debug controller (level, four-phase).
REQ-009 type_tx  input  1  0 = single character from dout_tx[7:0], 1 = 32-bit word as hex.
REQ-010 dout_tx  input  32  data to print.
REQ-011 ack_tx  output  1  request completed (level, four-phase).
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, SEND and DONE.
REQ-014 In IDLE with req_tx=1, the block SHALL on that edge do all of the following:
- latch type_tx and dout_tx;
- load the character counter;
- enter SEND.
REQ-015 Later changes on type_tx or dout_tx SHALL NOT affect a print in progress.
REQ-016 Character count per request SHALL be:
- 1 for type 0;
- 8 for type 1 with WORD_CRLF=0;
- 10 for type 1 with WORD_CRLF=1.
REQ-017 vld_tx SHALL be registered and SHALL rise on the edge after the request is sampled (one-cycle latency).
REQ-018 A byte SHALL transfer on any edge where vld_tx=1 and rdy_tx=1.
REQ-019 After a transfer, the next byte SHALL be presented on that same edge, so vld_tx stays high and back-to-back transfers run at one byte per cycle.
REQ-020 While vld_tx=1 and rdy_tx=0, d_tx and vld_tx SHALL hold their values unchanged.
REQ-021 Type 1 digits SHALL go out MSB nibble first, dout_tx[31:28] through [3:0]. Each nibble 0-9 maps to 0x30-0x39 and each nibble 10-15 maps to 0x41-0x46 (or 0x61-0x66 when HEX_UPPER=0). The CR and LF bytes follow when WORD_CRLF=1.
REQ-022 Type 0 SHALL send dout_tx[7:0] unmodified as exactly one byte.
REQ-023 On the transfer of the last byte, vld_tx SHALL drop, ack_tx SHALL rise on that same edge, and the FSM SHALL enter DONE.
REQ-024 In DONE, ack_tx SHALL remain high while req_tx=1. When req_tx=0, ack_tx SHALL drop and the FSM SHALL return to IDLE on the next edge.
REQ-025 A req_tx held high through DONE SHALL NOT start a second print; a new print requires req_tx low then high again.
REQ-026 req_tx falling while in SEND SHALL NOT abort the print. After the last transfer, DONE SHALL see req_tx=0 and return to IDLE after one ack_tx cycle.
REQ-027 Each request SHALL produce exactly one ack_tx assertion and no more than the byte count of REQ-016.

Reset
REQ-028 While rst=1, the following SHALL be forced immediately, independent of clk:
- state = IDLE;
- vld_tx = 0, ack_tx = 0, busy = 0;
- d_tx = 0x00;
- character counter and latched data = 0.
REQ-029 A reset asserted mid-print SHALL discard the remaining characters. After release, no byte SHALL be emitted until a new req_tx is sampled in IDLE.

Verification
REQ-030 The bench SHALL cover a single character: type 0, dout_tx=0x00000041, rdy_tx=1 -> exactly one transfer of 0x41, then ack_tx high until req_tx drops.
REQ-031 The bench SHALL cover a word with defaults: type 1, dout_tx=0x1234ABCD, rdy_tx=1 -> 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive edges, then ack_tx.
REQ-032 The bench SHALL cover lowercase with no terminator: HEX_UPPER=0, WORD_CRLF=0, dout_tx=0xDEADBEEF -> 64 65 61 64 62 65 65 66, with no 0D or 0A.
REQ-033 The bench SHALL cover backpressure: word 0x0000000F with rdy_tx low for 5 cycles at the 3rd byte -> d_tx held at 0x30 and vld_tx=1 throughout the stall, and the full sequence still correct.
REQ-034 The bench SHALL cover a held request: req_tx kept high for 20 cycles after ack_tx -> no further vld_tx; dropping and re-raising req_tx starts exactly one new print.
REQ-035 The bench SHALL cover reset mid-print: rst pulsed after the 4th byte of 0x89ABCDEF -> vld_tx, ack_tx and busy go to 0 immediately, and no bytes are emitted until the next request.

Source files
------------

// File: rtl/hex_printer.sv
// Debug print engine for a UART transmitter.
// A request either sends one raw character, or sends a 32-bit word as eight
// hex digits, optionally followed by CR LF.
// The request and acknowledge form a four-phase level handshake with the
// debug controller.
module hex_printer #(
  parameter int HEX_UPPER = 1,
  parameter int WORD_CRLF = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] WORD_LEN = (WORD_CRLF != 0) ? 4'd10 : 4'd8;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;      // characters still to be transferred
  logic [3:0]  idx, idx_nxt;      // position of the character on d_tx
  logic [31:0] data, data_nxt;    // payload captured at request time
  logic        word, word_nxt;    // captured request type
  logic [7:0]  d_nxt;
  logic        vld_nxt;
  logic        ack_nxt;
  logic        busy_nxt;

  // Map one nibble to its ASCII hex digit in the configured case.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else if (HEX_UPPER != 0) begin
      return 8'h37 + {4'h0, nib};   // 10 -> 0x41 'A'
    end else begin
      return 8'h57 + {4'h0, nib};   // 10 -> 0x61 'a'
    end
  endfunction

  // Character at position pos of a print: the raw byte for a character
  // request; for a word request, the hex digits MSB nibble first, then CR LF.
  function automatic logic [7:0] char_at(input logic [3:0]  pos,
                                         input logic [31:0] val,
                                         input logic        is_word);
    logic [31:0] shifted;
    shifted = val << {pos[2:0], 2'b00};
    if (!is_word) begin
      return val[7:0];
    end else if (pos == 4'd8) begin
      return 8'h0D;
    end else if (pos == 4'd9) begin
      return 8'h0A;
    end else begin
      return nib_to_ascii(shifted[31:28]);
    end
  endfunction

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    data_nxt  = data;
    word_nxt  = word;
    d_nxt     = d_tx;
    vld_nxt   = vld_tx;
    ack_nxt   = ack_tx;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        if (req_tx) begin
          data_nxt  = dout_tx;
          word_nxt  = type_tx;
          idx_nxt   = 4'd0;
          cnt_nxt   = type_tx ? WORD_LEN : 4'd1;
          d_nxt     = char_at(4'd0, dout_tx, type_tx);
          vld_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (vld_tx && rdy_tx) begin
          if (cnt == 4'd1) begin
            // Last byte accepted: finish and acknowledge on the same edge.
            cnt_nxt   = 4'd0;
            vld_nxt   = 1'b0;
            ack_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            // Present the following byte immediately for back-to-back flow.
            cnt_nxt = cnt - 4'd1;
            idx_nxt = idx + 4'd1;
            d_nxt   = char_at(idx + 4'd1, data, word);
          end
        end else begin
          state_nxt = SEND;
        end
      end
      DONE: begin
        if (!req_tx) begin
          ack_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        vld_nxt   = 1'b0;
        ack_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx    <= 4'd0;
      data   <= 32'd0;
      word   <= 1'b0;
      d_tx   <= 8'h00;
      vld_tx <= 1'b0;
      ack_tx <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      data   <= data_nxt;
      word   <= word_nxt;
      d_tx   <= d_nxt;
      vld_tx <= vld_nxt;
      ack_tx <= ack_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hex_printer.sv
// Scoreboard bench for hex_printer: stimulus pushes expected bytes, monitors
// pop and compare on every accepted transfer.
module tb_hex_printer;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  d_tx0, d_tx1;
  logic        vld0, vld1, rdy0, rdy1, req0, req1, type0, type1;
  logic        ack0, ack1, busy0, busy1;
  logic [31:0] dout0, dout1;

  logic [7:0]  exp_q0[$];
  logic [7:0]  exp_q1[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          acks0 = 0;
  int          acks1 = 0;
  logic        ack0_prev = 1'b0;
  logic        ack1_prev = 1'b0;

  hex_printer u_dut0 (
    .clk(clk), .rst(rst), .d_tx(d_tx0), .vld_tx(vld0), .rdy_tx(rdy0),
    .req_tx(req0), .type_tx(type0), .dout_tx(dout0), .ack_tx(ack0), .busy(busy0)
  );

  hex_printer #(.HEX_UPPER(0), .WORD_CRLF(0)) u_dut1 (
    .clk(clk), .rst(rst), .d_tx(d_tx1), .vld_tx(vld1), .rdy_tx(rdy1),
    .req_tx(req1), .type_tx(type1), .dout_tx(dout1), .ack_tx(ack1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input bit which, input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) exp_q1.push_back(v[79-8*i -: 8]);
      else exp_q0.push_back(v[79-8*i -: 8]);
    end
  endtask

  // Wait (bounded) for ack, then check the cycle count if one is given.
  task automatic wait_ack(input bit which, input int exp_cycles, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(which ? ack1 : ack0) && n < 200);
    check({name, " ack"}, {31'd0, (which ? ack1 : ack0)}, 32'd1);
    if (exp_cycles > 0) check({name, " cycles"}, n, exp_cycles);
    check({name, " drained"}, which ? exp_q1.size() : exp_q0.size(), 32'd0);
  endtask

  task automatic release_req(input bit which, input string name);
    if (which) req1 = 1'b0; else req0 = 1'b0;
    @(posedge clk); #1;
    check({name, " ack drop"}, {31'd0, (which ? ack1 : ack0)}, 32'd0);
    check({name, " busy drop"}, {31'd0, (which ? busy1 : busy0)}, 32'd0);
  endtask

  // Monitor for instance 0: compare each accepted byte and count ack rises.
  always @(negedge clk) begin
    if (vld0 && rdy0) begin
      if (exp_q0.size() == 0) begin
        total_cnt++;
        $display("FAIL inst0 unexpected byte: got %h expected none", d_tx0);
      end else begin
        check("inst0 byte", {24'd0, d_tx0}, {24'd0, exp_q0.pop_front()});
      end
    end
    if (ack0 && !ack0_prev) acks0++;
    ack0_prev = ack0;
  end

  // Monitor for instance 1: compare each accepted byte and count ack rises.
  always @(negedge clk) begin
    if (vld1 && rdy1) begin
      if (exp_q1.size() == 0) begin
        total_cnt++;
        $display("FAIL inst1 unexpected byte: got %h expected none", d_tx1);
      end else begin
        check("inst1 byte", {24'd0, d_tx1}, {24'd0, exp_q1.pop_front()});
      end
    end
    if (ack1 && !ack1_prev) acks1++;
    ack1_prev = ack1;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rdy0 = 1'b1; req0 = 1'b0; type0 = 1'b0; dout0 = 32'd0;
    rdy1 = 1'b1; req1 = 1'b0; type1 = 1'b0; dout1 = 32'd0;
    #2;
    check("reset vld0", {31'd0, vld0}, 32'd0);
    check("reset ack0", {31'd0, ack0}, 32'd0);
    check("reset busy0", {31'd0, busy0}, 32'd0);
    check("reset d_tx0", {24'd0, d_tx0}, 32'd0);
    check("reset vld1", {31'd0, vld1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single character.
    type0 = 1'b0; dout0 = 32'h0000_0041;
    push(1'b0, {8'h41, 72'd0}, 1);
    req0 = 1'b1;
    wait_ack(1'b0, 2, "char");
    repeat (2) begin
      @(posedge clk); #1;
      check("char ack hold", {31'd0, ack0}, 32'd1);
      check("char no vld", {31'd0, vld0}, 32'd0);
    end
    release_req(1'b0, "char");

    // Word, uppercase with CR LF.
    type0 = 1'b1; dout0 = 32'h1234_ABCD;
    push(1'b0, 80'h3132_3334_4142_4344_0D0A, 10);
    req0 = 1'b1;
    @(posedge clk); #1;
    dout0 = 32'hFFFF_FFFF; type0 = 1'b0;   // must not disturb the print
    wait_ack(1'b0, 10, "word");
    release_req(1'b0, "word");

    // Lowercase, no terminator.
    type1 = 1'b1; dout1 = 32'hDEAD_BEEF;
    push(1'b1, {64'h6465_6164_6265_6566, 16'd0}, 8);
    req1 = 1'b1;
    wait_ack(1'b1, 9, "lower");
    check("lower vld low", {31'd0, vld1}, 32'd0);
    release_req(1'b1, "lower");

    // Backpressure at the 3rd byte; req dropped early during SEND.
    type0 = 1'b1; dout0 = 32'h0000_000F;
    push(1'b0, 80'h3030_3030_3030_3046_0D0A, 10);
    req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rdy0 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall vld", {31'd0, vld0}, 32'd1);
      check("stall d_tx", {24'd0, d_tx0}, 32'h30);
    end
    rdy0 = 1'b1;
    wait_ack(1'b0, 8, "stall");
    @(posedge clk); #1;
    check("early drop ack", {31'd0, ack0}, 32'd0);
    check("early drop busy", {31'd0, busy0}, 32'd0);

    // Held request must not restart; re-raise starts exactly one print.
    type0 = 1'b0; dout0 = 32'h0000_005A;
    push(1'b0, {8'h5A, 72'd0}, 1);
    req0 = 1'b1;
    wait_ack(1'b0, 2, "held");
    repeat (20) begin
      @(posedge clk); #1;
      check("held no vld", {31'd0, vld0}, 32'd0);
      check("held ack", {31'd0, ack0}, 32'd1);
    end
    release_req(1'b0, "held");
    @(posedge clk); #1;
    dout0 = 32'h0000_0021;
    push(1'b0, {8'h21, 72'd0}, 1);
    req0 = 1'b1;
    wait_ack(1'b0, 2, "reraise");
    release_req(1'b0, "reraise");
    repeat (5) begin
      @(posedge clk); #1;
      check("idle no vld", {31'd0, vld0}, 32'd0);
    end

    // Reset in the middle of a word.
    type0 = 1'b1; dout0 = 32'h89AB_CDEF;
    push(1'b0, 80'h3839_4142_4344_4546_0D0A, 10);
    req0 = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("mid bytes left", exp_q0.size(), 32'd6);
    rst = 1'b1; req0 = 1'b0;
    #1;
    check("mid rst vld", {31'd0, vld0}, 32'd0);
    check("mid rst ack", {31'd0, ack0}, 32'd0);
    check("mid rst busy", {31'd0, busy0}, 32'd0);
    check("mid rst d_tx", {24'd0, d_tx0}, 32'd0);
    exp_q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("post rst vld", {31'd0, vld0}, 32'd0);
      check("post rst busy", {31'd0, busy0}, 32'd0);
    end
    type0 = 1'b0; dout0 = 32'h0000_0041;
    push(1'b0, {8'h41, 72'd0}, 1);
    req0 = 1'b1;
    wait_ack(1'b0, 2, "recover");
    release_req(1'b0, "recover");

    @(posedge clk); #1;
    check("ack count inst0", acks0, 32'd6);
    check("ack count inst1", acks1, 32'd1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
